// File: rtl/mac_multi_job_fsm_pkg.sv
// Shared types and default widths for the multi-job MAC controller, its
// regfile and the top level.
package mac_multi_package;

  typedef enum logic [2:0] {
    IDLE,
    START,
    COMPUTE,
    UPDATE,
    WAIT,
    TERMINATE
  } state_fsm_multi_t;

  localparam int NB_STREAMS_DEF = 4;
  localparam int ADDR_W_DEF     = 32;
  localparam int LEN_W_DEF      = 16;
  localparam int ITER_W_DEF     = 16;
  localparam int STALL_W_DEF    = 32;

endpackage

// File: rtl/mac_multi_job_fsm_if.sv
// Job/streamer/engine bundle of the multi-job MAC controller.
// slave = controller side, master = regfile/streamer/engine side.
interface mac_multi_job_fsm_if
  import mac_multi_package::*;
#(
  parameter int NB_STREAMS = NB_STREAMS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int ITER_W     = ITER_W_DEF,
  parameter int STALL_W    = STALL_W_DEF
);
  logic                                test_mode_i;
  logic                                clear_i;
  logic                                start_i;
  logic [LEN_W-1:0]                    len_i;
  logic [ITER_W-1:0]                   nb_iter_i;
  logic [NB_STREAMS-1:0]               stream_en_i;
  logic [NB_STREAMS-1:0][ADDR_W-1:0]   base_addr_i;
  logic [NB_STREAMS-1:0][ADDR_W-1:0]   stride_i;
  logic [NB_STREAMS-1:0]               ready_start_i;
  logic [NB_STREAMS-1:0]               req_start_o;
  logic [NB_STREAMS-1:0][ADDR_W-1:0]   addr_o;
  logic [LEN_W-1:0]                    len_o;
  logic [LEN_W-1:0]                    engine_cnt_i;
  logic                                engine_acc_valid_i;
  logic                                engine_start_o;
  logic                                engine_clear_o;
  logic                                engine_enable_o;
  logic                                busy_o;
  logic                                done_o;
  logic                                evt_o;
  logic [ITER_W-1:0]                   iter_o;
  logic [STALL_W-1:0]                  stall_cnt_o;

  modport slave (
    input  test_mode_i, clear_i, start_i, len_i, nb_iter_i, stream_en_i,
           base_addr_i, stride_i, ready_start_i, engine_cnt_i, engine_acc_valid_i,
    output req_start_o, addr_o, len_o, engine_start_o, engine_clear_o,
           engine_enable_o, busy_o, done_o, evt_o, iter_o, stall_cnt_o
  );

  modport master (
    output test_mode_i, clear_i, start_i, len_i, nb_iter_i, stream_en_i,
           base_addr_i, stride_i, ready_start_i, engine_cnt_i, engine_acc_valid_i,
    input  req_start_o, addr_o, len_o, engine_start_o, engine_clear_o,
           engine_enable_o, busy_o, done_o, evt_o, iter_o, stall_cnt_o
  );
endinterface

// File: rtl/mac_multi_job_fsm_addrgen.sv
// Per-stream address registers: load base/stride at job start, step by
// stride after each non-final iteration (wraps modulo 2^ADDR_W).
module mac_multi_addrgen #(
  parameter int NB_STREAMS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              clear,
  input  logic                              load,
  input  logic                              step,
  input  logic [NB_STREAMS-1:0][ADDR_W-1:0] base,
  input  logic [NB_STREAMS-1:0][ADDR_W-1:0] stride,
  output logic [NB_STREAMS-1:0][ADDR_W-1:0] addr
);
  logic [NB_STREAMS-1:0][ADDR_W-1:0] addr_q, stride_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else if (clear) begin
      addr_q   <= '0;
    end else if (load) begin
      addr_q   <= base;
      stride_q <= stride;
    end else if (step) begin
      for (int s = 0; s < NB_STREAMS; s++) addr_q[s] <= addr_q[s] + stride_q[s];
    end
  end

  assign addr = addr_q;
endmodule

// File: rtl/mac_multi_job_fsm.sv
// Multi-iteration MAC job sequencer: issues streamer/engine starts per
// iteration, steps stream addresses, counts iterations and stall cycles.
module mac_multi_job_fsm
  import mac_multi_package::*;
#(
  parameter int NB_STREAMS = NB_STREAMS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int ITER_W     = ITER_W_DEF,
  parameter int STALL_W    = STALL_W_DEF
) (
  input logic               clk_i,
  input logic               rst_ni,
  mac_multi_job_fsm_if.slave bus
);
  state_fsm_multi_t       state_q, state_d;
  logic [LEN_W-1:0]       len_q;
  logic [ITER_W-1:0]      nb_iter_q, iter_q;
  logic [NB_STREAMS-1:0]  en_q;
  logic [STALL_W-1:0]     stall_q;
  logic                   all_rdy, last_iter, load, step, issue;
  logic                   eng_clear, eng_enable, done, evt;

  // Disabled streams are treated as permanently ready.
  assign all_rdy   = &(bus.ready_start_i | ~en_q);
  assign last_iter = (iter_q == nb_iter_q - ITER_W'(1));

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    step       = 1'b0;
    issue      = 1'b0;
    eng_clear  = 1'b1;
    eng_enable = 1'b1;
    done       = 1'b0;
    evt        = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) begin
        load    = 1'b1;
        state_d = START;
      end
      START, WAIT: begin
        if (state_q == WAIT) begin
          eng_clear  = 1'b0;
          eng_enable = 1'b0;
        end
        if (all_rdy) begin
          // Zero-length iterations skip the streams and engine entirely.
          if (len_q == '0) state_d = UPDATE;
          else begin
            issue      = 1'b1;
            eng_enable = 1'b1;
            state_d    = COMPUTE;
          end
        end else begin
          state_d = WAIT;
        end
      end
      COMPUTE: begin
        eng_clear = 1'b0;
        if (bus.engine_cnt_i == len_q && bus.engine_acc_valid_i) state_d = UPDATE;
      end
      UPDATE: begin
        if (last_iter) state_d = TERMINATE;
        else begin
          evt     = 1'b1;
          step    = 1'b1;
          state_d = WAIT;
        end
      end
      TERMINATE: begin
        eng_clear  = 1'b0;
        eng_enable = 1'b0;
        if (all_rdy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear_i) begin
      state_d = IDLE;
      load    = 1'b0;
      step    = 1'b0;
      issue   = 1'b0;
      done    = 1'b0;
      evt     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q     <= '0;
      nb_iter_q <= ITER_W'(1);
      en_q      <= '0;
      iter_q    <= '0;
      stall_q   <= '0;
    end else if (bus.clear_i) begin
      len_q   <= '0;
      iter_q  <= '0;
      stall_q <= '0;
    end else if (load) begin
      len_q     <= bus.len_i;
      nb_iter_q <= (bus.nb_iter_i == '0) ? ITER_W'(1) : bus.nb_iter_i;
      en_q      <= bus.stream_en_i;
      iter_q    <= '0;
      stall_q   <= '0;
    end else begin
      if (step) iter_q <= iter_q + ITER_W'(1);
      if ((state_q == WAIT || state_q == TERMINATE) && !all_rdy && stall_q != '1)
        stall_q <= stall_q + STALL_W'(1);
    end
  end

  mac_multi_addrgen #(
    .NB_STREAMS (NB_STREAMS),
    .ADDR_W     (ADDR_W)
  ) u_addrgen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (bus.clear_i),
    .load   (load),
    .step   (step),
    .base   (bus.base_addr_i),
    .stride (bus.stride_i),
    .addr   (bus.addr_o)
  );

  assign bus.req_start_o     = issue ? en_q : '0;
  assign bus.engine_start_o  = issue;
  assign bus.engine_clear_o  = eng_clear;
  assign bus.engine_enable_o = eng_enable;
  assign bus.len_o           = len_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.done_o          = done;
  assign bus.evt_o           = evt;
  assign bus.iter_o          = iter_q;
  assign bus.stall_cnt_o     = stall_q;
endmodule

// File: tb/tb_mac_multi_job_fsm.sv
// Job-level bench: random and directed jobs checked against expected issue
// addresses, event/done counts and stall figures derived per job.
module tb_mac_multi_job_fsm;
  localparam int NS = 4, AW = 32, LW = 16, IW = 16, SW = 32;

  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;

  mac_multi_job_fsm_if #(.NB_STREAMS(NS), .ADDR_W(AW), .LEN_W(LW), .ITER_W(IW), .STALL_W(SW)) bus ();

  mac_multi_job_fsm #(.NB_STREAMS(NS), .ADDR_W(AW), .LEN_W(LW), .ITER_W(IW), .STALL_W(SW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0, n_err = 0;

  logic [LW-1:0]          j_len;
  int                     j_n;
  logic [NS-1:0]          j_en;
  logic [NS-1:0][AW-1:0]  j_base, j_stride;
  int rdy_mode, hold, eng_cd, tick_no, stall_test;
  int issues, evts, dones, done_tick, first_issue_tick, evt_tick, issue2_tick, nrdy;
  logic [IW-1:0] done_iter;
  logic [SW-1:0] done_stall;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NS-1:0][AW-1:0] exp_addr(input int k);
    logic [NS-1:0][AW-1:0] r;
    for (int s = 0; s < NS; s++) r[s] = j_base[s] + AW'(k) * j_stride[s];
    return r;
  endfunction

  // One clock: drive streams/engine, observe outputs, then advance.
  task automatic tick();
    logic [NS-1:0] r;
    case (rdy_mode)
      0:       r = '1;
      1:       r = NS'($urandom | $urandom);
      default: r = 4'b1011;
    endcase
    if (hold > 0) r[2] = 1'b0;
    bus.ready_start_i = r;
    if (eng_cd == 1) begin
      bus.engine_cnt_i = j_len;
      bus.engine_acc_valid_i = 1'b1;
    end else if ($urandom_range(0, 1) == 1) begin
      bus.engine_cnt_i = j_len;
      bus.engine_acc_valid_i = 1'b0;
    end else begin
      bus.engine_cnt_i = j_len + 16'd1;
      bus.engine_acc_valid_i = 1'b1;
    end
    #1;
    chk("req_start", bus.req_start_o, bus.engine_start_o ? j_en : '0);
    if (bus.engine_start_o) begin
      chk("issue_addr", bus.addr_o, exp_addr(issues));
      if (issues == 0) first_issue_tick = tick_no;
      if (issues == 1) issue2_tick = tick_no;
      issues++;
    end
    if (hold > 0) hold--;
    if (bus.evt_o) begin
      evts++;
      evt_tick = tick_no;
      if (stall_test != 0 && evts == 1) hold = 5;
    end
    if (bus.done_o) begin
      dones++;
      done_tick  = tick_no;
      done_iter  = bus.iter_o;
      done_stall = bus.stall_cnt_o;
    end
    if (bus.busy_o && ((r | ~j_en) != '1)) nrdy++;
    if (eng_cd > 0) eng_cd--;
    if (bus.engine_start_o) eng_cd = $urandom_range(1, 3);
    tick_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic setup_job(input logic [LW-1:0] len, input int nbi, input logic [NS-1:0] en,
                           input logic [NS-1:0][AW-1:0] base, input logic [NS-1:0][AW-1:0] stride,
                           input int mode, input int stall);
    j_len = len; j_n = (nbi == 0) ? 1 : nbi; j_en = en; j_base = base; j_stride = stride;
    rdy_mode = mode; stall_test = stall; hold = 0; eng_cd = 0; tick_no = 0;
    issues = 0; evts = 0; dones = 0; done_tick = 0; first_issue_tick = -1;
    evt_tick = 0; issue2_tick = -1; nrdy = 0; done_iter = '0; done_stall = '0;
    bus.len_i = len; bus.nb_iter_i = IW'(nbi); bus.stream_en_i = en;
    bus.base_addr_i = base; bus.stride_i = stride;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    // Job inputs are latched at start; scramble them to prove it.
    bus.len_i = LW'($urandom); bus.nb_iter_i = IW'($urandom); bus.stream_en_i = NS'($urandom);
    for (int s = 0; s < NS; s++) begin
      bus.base_addr_i[s] = $urandom; bus.stride_i[s] = $urandom;
    end
  endtask

  task automatic run_job(input logic [LW-1:0] len, input int nbi, input logic [NS-1:0] en,
                         input logic [NS-1:0][AW-1:0] base, input logic [NS-1:0][AW-1:0] stride,
                         input int mode, input int stall, input int busy_start);
    setup_job(len, nbi, en, base, stride, mode, stall);
    while (dones == 0 && tick_no < 300) begin
      bus.start_i = (busy_start != 0 && tick_no == 3);
      tick();
    end
    bus.start_i = 1'b0;
    chk("done_cnt", dones, 1);
    chk("issue_cnt", issues, (len != 0) ? j_n : 0);
    chk("evt_cnt", evts, j_n - 1);
    chk("iter_at_done", done_iter, IW'(j_n - 1));
    chk("busy_after_done", bus.busy_o, 1'b0);
    chk("idle_clear_en", {bus.engine_clear_o, bus.engine_enable_o}, 2'b11);
    if (mode == 0 && len != 0 && stall == 0) chk("first_issue_lat", first_issue_tick, 1);
    if (mode == 0 && len == 0 && j_n == 1) chk("len0_done_lat", done_tick <= 4, 1'b1);
    if (stall != 0) begin
      chk("stall_cnt", done_stall, 5);
      chk("stall_reissue", issue2_tick, evt_tick + 6);
    end else if (mode == 0) chk("stall_zero", done_stall, 0);
    else chk("stall_bound", done_stall <= SW'(nrdy), 1'b1);
  endtask

  logic [NS-1:0][AW-1:0] b, st;

  initial begin
    rst_n = 1'b0;
    bus.test_mode_i = 1'b0; bus.clear_i = 1'b0; bus.start_i = 1'b0;
    bus.len_i = '0; bus.nb_iter_i = '0; bus.stream_en_i = '0;
    bus.base_addr_i = '0; bus.stride_i = '0; bus.ready_start_i = '1;
    bus.engine_cnt_i = '0; bus.engine_acc_valid_i = 1'b0;
    j_en = '0; j_len = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_clear_en", {bus.engine_clear_o, bus.engine_enable_o}, 2'b11);
    chk("rst_pulses", {bus.req_start_o, bus.engine_start_o, bus.done_o, bus.evt_o}, '0);
    chk("rst_iter", bus.iter_o, '0);
    chk("rst_stall", bus.stall_cnt_o, '0);
    chk("rst_addr", bus.addr_o, '0);
    chk("rst_len", bus.len_o, '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic job
    b = '0; st = '0; b[0] = 32'h100; st[0] = 32'h10;
    b[1] = 32'h2000; st[1] = 32'h4;
    run_job(16'd4, 3, 4'b1111, b, st, 0, 0, 0);

    // Stall on stream 2 after the first UPDATE
    for (int s = 0; s < NS; s++) begin b[s] = $urandom; st[s] = $urandom; end
    run_job(16'd3, 2, 4'b1111, b, st, 0, 1, 0);

    // Disabled stream never ready
    run_job(16'd2, 3, 4'b1011, b, st, 2, 0, 0);

    // Abort in COMPUTE of iteration 1, then a fresh job
    setup_job(16'd4, 4, 4'b1111, b, st, 0, 0);
    while ((evts < 1 || issues < 2) && tick_no < 200) tick();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    eng_cd = 0;
    chk("abort_busy", bus.busy_o, 1'b0);
    chk("abort_iter", bus.iter_o, '0);
    chk("abort_addr", bus.addr_o, '0);
    chk("abort_no_done", dones, 0);
    chk("abort_len", bus.len_o, '0);
    run_job(16'd1, 2, 4'b0101, b, st, 0, 0, 0);

    // clear_i together with start_i stays idle
    bus.clear_i = 1'b1; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.clear_i = 1'b0; bus.start_i = 1'b0;
    chk("clr_start_busy", bus.busy_o, 1'b0);
    @(posedge clk); #1;
    chk("clr_start_busy2", bus.busy_o, 1'b0);

    // Corners: nb_iter=0, len=0, start while busy, engine-only job
    run_job(16'd3, 0, 4'b1111, b, st, 0, 0, 0);
    run_job(16'd0, 1, 4'b1111, b, st, 0, 0, 0);
    run_job(16'd0, 3, 4'b1111, b, st, 0, 0, 0);
    run_job(16'd2, 3, 4'b1111, b, st, 0, 0, 1);
    run_job(16'd2, 2, 4'b0000, b, st, 1, 0, 0);

    // Address wrap
    b[0] = 32'hFFFF_FFF0; st[0] = 32'h20;
    run_job(16'd2, 2, 4'b0001, b, st, 0, 0, 0);

    // Random jobs with random readiness
    for (int j = 0; j < 25; j++) begin
      for (int s = 0; s < NS; s++) begin b[s] = $urandom; st[s] = $urandom; end
      run_job(LW'($urandom_range(0, 5)), $urandom_range(0, 4), NS'($urandom), b, st,
              $urandom_range(0, 1), 0, $urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mac_multi_job_fsm.md
Name: mac_multi_job_fsm

Overview:
- Parametrised successor to the MAC engine control FSM.
- Sequences a job of NB_ITER iterations over NB_STREAMS generic streams (sources and sinks) with per-stream enable.
- Generates per-iteration addresses internally (base + iter*stride), so no external uloop is needed. Adds per-iteration events, a busy flag, an iteration index and a stall counter.
- Sits between the HWPE slave/regfile and the streamer/engine.

Parameters:
NB_STREAMS, 4, number of controlled streams (index 0..NB_STREAMS-1)
ADDR_W, 32, address width
LEN_W, 16, vector length / engine counter width
ITER_W, 16, iteration counter width
STALL_W, 32, stall counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_mode_i  in  1  test mode; no functional effect
clear_i  in  1  synchronous soft clear/abort
start_i  in  1  job start pulse (slave)
len_i  in  LEN_W  elements per iteration
nb_iter_i  in  ITER_W  iterations per job; 0 treated as 1
stream_en_i  in  NB_STREAMS  per-stream enable
base_addr_i  in  NB_STREAMS*ADDR_W  per-stream base address
stride_i  in  NB_STREAMS*ADDR_W  per-stream per-iteration stride
ready_start_i  in  NB_STREAMS  streamer ready_start flags
req_start_o  out  NB_STREAMS  streamer start pulses
addr_o  out  NB_STREAMS*ADDR_W  current per-stream base address
len_o  out  LEN_W  latched length to streamer/engine
engine_cnt_i  in  LEN_W  engine element count
engine_acc_valid_i  in  1  engine accumulator valid
engine_start_o  out  1  engine start pulse
engine_clear_o  out  1  engine clear
engine_enable_o  out  1  engine enable
busy_o  out  1  job active
done_o  out  1  job-complete pulse
evt_o  out  1  iteration-complete pulse
iter_o  out  ITER_W  current iteration index
stall_cnt_o  out  STALL_W  cycles stalled waiting for streams

Behaviour:
- States: IDLE, START, COMPUTE, UPDATE, WAIT, TERMINATE. Registered state; outputs are decoded combinationally from state and inputs.
- Reset, and clear_i in any state: state IDLE; iter, addr, len and stall registers set to 0; clear_i produces no done_o.
- Outputs in reset/IDLE: engine_clear_o=1, engine_enable_o=1; all other outputs 0.
- all_rdy = AND over s of (ready_start_i[s] | ~en_q[s]). Disabled streams never receive req_start_o.
- Issue: req_start_o = en_q, engine_start_o=1, engine_enable_o=1 for exactly one cycle.
- IDLE: start_i=1 latches len_i, max(nb_iter_i,1), stream_en_i, base_addr_i, stride_i; sets addr=base, iter=0, stall=0; next state START. start_i outside IDLE is ignored.
- START: if all_rdy, issue and go to COMPUTE; else go to WAIT. Minimum latency is start_i to first req_start_o = 1 cycle.
- COMPUTE: engine_clear_o=0. When engine_cnt_i==len_q and engine_acc_valid_i=1, go to UPDATE.
- UPDATE (1 cycle):
  - If iter==nb_iter_q-1: go to TERMINATE.
  - Else: evt_o=1; iter+=1; addr[s]+=stride[s], all streams, modulo 2^ADDR_W; go to WAIT.
  - evt_o does not fire on the last iteration; done_o covers it.
- WAIT: engine_clear_o=0, engine_enable_o=0. If all_rdy, issue and go to COMPUTE.
- TERMINATE: engine_clear_o=0, engine_enable_o=0. When all_rdy, done_o=1 for 1 cycle and go to IDLE.
- len_q==0: START/WAIT go directly to UPDATE on all_rdy with no issue. An iteration thus takes 2 cycles and produces no stream traffic.
- stall_cnt increments in WAIT/TERMINATE while all_rdy=0; saturates at all-ones.
- busy_o=1 in every state except IDLE.
- Simultaneous clear_i and start_i: clear wins; the FSM stays in IDLE.
- All stream_en_i=0: all_rdy is constant 1; the job runs with engine only.

Decomposition:
- Package mac_multi_package: the state enum (state_fsm_multi_t) and width localparams reused by the regfile and top-level.
- One sub-module, mac_multi_addrgen: NB_STREAMS address registers with load/step, instantiated once.
- FSM, iteration counter and stall counter stay in the top module.

Test Plan:
1. Basic job (len=4, nb_iter=3, en=4'b1111, base[0]=0x100, stride[0]=0x10, all ready):
   - addr_o[0] sequence 0x100, 0x110, 0x120.
   - 3 issues, 2 evt_o pulses, 1 done_o; iter_o ends at 2.
2. Stall (ready_start_i[2]=0 for 5 cycles after UPDATE):
   - State held in WAIT, no req_start_o, stall_cnt_o=5; issue on the first cycle ready returns.
3. Disabled stream (en=4'b1011, ready_start_i[2]=0 always):
   - Job completes; req_start_o[2] never asserted.
4. Abort (clear_i in COMPUTE, iteration 1 of 4):
   - IDLE next cycle, busy_o=0, no done_o, iter_o=0.
   - A new start_i afterwards runs normally.
5. Corner cases (nb_iter=0, len=0, plus start_i while busy):
   - nb_iter=0 runs exactly 1 iteration.
   - len=0 gives no req_start_o, done_o within 4 cycles of START.
   - start_i while busy is ignored.
6. Address wrap (base=0xFFFF_FFF0, stride=0x20, 2 iterations):
   - Second addr_o = 0x0000_0010.
